// File: rtl/uart_frame_rx_if.sv
// uart_frame_rx_if: serial input and frame-result outputs of the UART frame receiver.
// master = line/consumer side, slave = receiver.
interface uart_frame_rx_if #(
  parameter int FULL_DATA_SIZE = 40
);
  logic                      in_bit;
  logic [FULL_DATA_SIZE-1:0] out_data;
  logic                      out_valid;
  logic                      frame_err;
  logic                      busy;

  modport master (output in_bit, input out_data, out_valid, frame_err, busy);
  modport slave  (input in_bit, output out_data, out_valid, frame_err, busy);
endinterface

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: UART receiver that gathers FULL_DATA_SIZE/BYTE_SIZE characters
// into one wide word (first character in the top byte) and pulses out_valid.
// Optional even-parity bit per character: define UART_FRAME_RX_PARITY_EN.
module uart_frame_rx #(
  parameter int FULL_DATA_SIZE = 40,
  parameter int BYTE_SIZE      = 8,
  parameter int CLKS_PER_BIT   = 4,
  parameter int TIMEOUT_BITS   = 16
) (
  input logic            CLK,
  input logic            RST_N,
  uart_frame_rx_if.slave rx
);
  localparam int NUM_BYTES = FULL_DATA_SIZE / BYTE_SIZE;
  localparam int TMR_W     = $clog2(CLKS_PER_BIT);
  localparam int BIT_W     = $clog2(BYTE_SIZE + 1);
  localparam int CNT_W     = $clog2(NUM_BYTES + 1);
  localparam int GAP_LIM   = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int GAP_W     = $clog2(GAP_LIM + 1);

  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLKS_PER_BIT / 2);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BYTE_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LIM - 1);

`ifdef UART_FRAME_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;
`endif

  state_t state_q, state_d;

  logic                      rx_meta, rx_s;
  logic [TMR_W-1:0]          tmr_q;
  logic [BIT_W-1:0]          bit_cnt_q;
  logic [CNT_W-1:0]          byte_cnt_q;
  logic [GAP_W-1:0]          gap_q;
  logic [BYTE_SIZE-1:0]      byte_sr;
  logic [FULL_DATA_SIZE-1:0] frame_sr, frame_nxt;
  logic [FULL_DATA_SIZE-1:0] out_data_q;
  logic                      out_valid_q, frame_err_q, busy_q;

  // control strobes from the FSM to the datapath
  logic tmr_clr, mid, start_ok, shift_bit, byte_ok, abort, timeout;

  assign mid       = (tmr_q == TMR_LAST);
  assign frame_nxt = (frame_sr << BYTE_SIZE) | FULL_DATA_SIZE'(byte_sr);

  // state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next state and per-cycle control strobes; the timer runs only inside a character
  always_comb begin
    state_d   = state_q;
    tmr_clr   = 1'b0;
    start_ok  = 1'b0;
    shift_bit = 1'b0;
    byte_ok   = 1'b0;
    abort     = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmr_clr = 1'b1;
        // the gap timer only matters once part of a frame has arrived
        if (byte_cnt_q != '0 && gap_q == GAP_LAST) timeout = 1'b1;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (tmr_q == TMR_HALF) begin
          tmr_clr = 1'b1;
          if (rx_s) state_d = S_IDLE;      // glitch: keep any partial frame
          else begin
            state_d  = S_DATA;
            start_ok = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (mid) begin
          tmr_clr   = 1'b1;
          shift_bit = 1'b1;
`ifdef UART_FRAME_RX_PARITY_EN
          if (bit_cnt_q == BIT_LAST) state_d = S_PARITY;
`else
          if (bit_cnt_q == BIT_LAST) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_FRAME_RX_PARITY_EN
      S_PARITY: begin
        if (mid) begin
          tmr_clr = 1'b1;
          // even parity: the parity bit equals the XOR of the data bits
          if (rx_s != ^byte_sr) begin
            abort   = 1'b1;
            state_d = S_WAIT_HIGH;
          end else begin
            state_d = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (mid) begin
          tmr_clr = 1'b1;
          if (rx_s) begin
            byte_ok = 1'b1;
            state_d = S_IDLE;
          end else begin
            abort   = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        // a held-low line (break) must not be decoded as characters
        tmr_clr = 1'b1;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        tmr_clr = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // synchroniser, bit timer, shift registers, frame counters and output pulses
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      tmr_q       <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      gap_q       <= '0;
      byte_sr     <= '0;
      frame_sr    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_meta     <= rx.in_bit;
      rx_s        <= rx_meta;
      tmr_q       <= tmr_clr ? '0 : tmr_q + 1'b1;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;

      if (start_ok) begin
        busy_q    <= 1'b1;
        bit_cnt_q <= '0;
      end
      if (shift_bit) begin
        byte_sr   <= {rx_s, byte_sr[BYTE_SIZE-1:1]};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (state_q == S_IDLE && byte_cnt_q != '0) gap_q <= gap_q + 1'b1;

      if (byte_ok) begin
        frame_sr <= frame_nxt;
        gap_q    <= '0;
        if (byte_cnt_q == CNT_LAST) begin
          out_data_q  <= frame_nxt;
          out_valid_q <= 1'b1;
          byte_cnt_q  <= '0;
          busy_q      <= 1'b0;
        end else begin
          byte_cnt_q <= byte_cnt_q + 1'b1;
        end
      end

      // a partial frame needs no clearing: the next full frame shifts it out
      if (abort || timeout) begin
        frame_err_q <= 1'b1;
        byte_cnt_q  <= '0;
        gap_q       <= '0;
        busy_q      <= 1'b0;
      end
    end
  end

  assign rx.out_data  = out_data_q;
  assign rx.out_valid = out_valid_q;
  assign rx.frame_err = frame_err_q;
  assign rx.busy      = busy_q;
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed frames through the serial line; a frame-level model
// (queue of expected words, pulse counters) is checked by one per-cycle monitor.
module tb_uart_frame_rx;
  localparam int FDS = 40, BS = 8, CPB = 4, TOB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_frame_rx_if #(.FULL_DATA_SIZE(FDS)) u_if ();

  uart_frame_rx #(
    .FULL_DATA_SIZE(FDS), .BYTE_SIZE(BS), .CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)
  ) u_dut (
    .CLK(clk), .RST_N(rst_n), .rx(u_if)
  );

  int checks = 0, errors = 0;
  int valid_seen = 0, err_seen = 0;
  logic [FDS-1:0] exp_q[$];
  logic [FDS-1:0] last_data = '0;

  task automatic check(input string name, input logic [FDS-1:0] act, input logic [FDS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pulses exclusive, data held between pulses, each pulse matches the next expected frame
  always @(negedge clk) begin
    if (!rst_n) begin
      last_data = '0;
    end else begin
      check("valid_err_exclusive", FDS'(u_if.out_valid & u_if.frame_err), '0);
      if (u_if.out_valid) begin
        valid_seen++;
        check("valid_expected", FDS'(exp_q.size() != 0), FDS'(1));
        if (exp_q.size() != 0) check("frame_data", u_if.out_data, exp_q.pop_front());
      end else begin
        check("data_hold", u_if.out_data, last_data);
      end
      if (u_if.frame_err) err_seen++;
      last_data = u_if.out_data;
    end
  end

  task automatic bit_out(input logic v);
    u_if.in_bit = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int bits);
    u_if.in_bit = 1'b1;
    repeat (bits * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [BS-1:0] d, input logic stop = 1'b1);
    bit_out(1'b0);
    for (int i = 0; i < BS; i++) bit_out(d[i]);
`ifdef UART_FRAME_RX_PARITY_EN
    bit_out(^d);
`endif
    bit_out(stop);
  endtask

`ifdef UART_FRAME_RX_PARITY_EN
  task automatic send_byte_badpar(input logic [BS-1:0] d);
    bit_out(1'b0);
    for (int i = 0; i < BS; i++) bit_out(d[i]);
    bit_out(~(^d));
    bit_out(1'b1);
  endtask
`endif

  // serialise a frame first byte first; the model expects exactly that word back
  task automatic send_frame(input logic [FDS-1:0] f, input logic [FDS-1:0] expect_word);
    exp_q.push_back(expect_word);
    for (int b = 0; b < FDS / BS; b++) send_byte(f[FDS-1-b*BS -: BS]);
  endtask

  int v0, e0;
  logic [FDS-1:0] w;

  initial begin
    u_if.in_bit = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_data", u_if.out_data, '0);
    check("rst_out_valid", FDS'(u_if.out_valid), '0);
    check("rst_frame_err", FDS'(u_if.frame_err), '0);
    check("rst_busy", FDS'(u_if.busy), '0);
    rst_n = 1'b1;
    idle(2);

    // basic frame; literal pins the byte order and LSB-first bit order
    v0 = valid_seen; e0 = err_seen;
    w = 40'h0003AABB47;
    exp_q.push_back(40'h0003AABB47);
    send_byte(w[39:32]); send_byte(w[31:24]);
    check("busy_mid_frame", FDS'(u_if.busy), FDS'(1));
    send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
    idle(2);
    check("t1_valid_count", FDS'(valid_seen - v0), FDS'(1));
    check("t1_err_count", FDS'(err_seen - e0), '0);
    check("t1_busy_after", FDS'(u_if.busy), '0);

    // one-cycle glitch is not a start bit
    v0 = valid_seen; e0 = err_seen;
    u_if.in_bit = 1'b0;
    @(negedge clk);
    u_if.in_bit = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch_busy", FDS'(u_if.busy), '0);
    idle(3);
    check("glitch_pulses", FDS'((valid_seen - v0) + (err_seen - e0)), '0);
    send_frame(40'h1122334455, 40'h1122334455);
    idle(2);
    check("t2_valid_count", FDS'(valid_seen - v0), FDS'(1));

    // stop-bit error on byte 3 followed by a long break
    v0 = valid_seen; e0 = err_seen;
    send_byte(8'hC1); send_byte(8'h5E); send_byte(8'h7F, 1'b0);
    u_if.in_bit = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    check("break_err_count", FDS'(err_seen - e0), FDS'(1));
    check("break_busy", FDS'(u_if.busy), '0);
    idle(2);
    check("break_no_valid", FDS'(valid_seen - v0), '0);
    send_frame(40'hDEADBEEF12, 40'hDEADBEEF12);
    idle(2);
    check("t3_valid_count", FDS'(valid_seen - v0), FDS'(1));
    check("t3_err_count", FDS'(err_seen - e0), FDS'(1));

    // inter-byte timeout after two bytes
    v0 = valid_seen; e0 = err_seen;
    send_byte(8'h99); send_byte(8'h88);
    idle(14);
    check("gap14_no_err", FDS'(err_seen - e0), '0);
    check("gap14_busy", FDS'(u_if.busy), FDS'(1));
    idle(3);
    check("gap17_err", FDS'(err_seen - e0), FDS'(1));
    check("gap17_busy", FDS'(u_if.busy), '0);
    send_frame(40'h0A0B0C0D0E, 40'h0A0B0C0D0E);
    idle(2);
    check("t4_valid_count", FDS'(valid_seen - v0), FDS'(1));

    // asynchronous reset in the middle of the fourth byte
    v0 = valid_seen;
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
    bit_out(1'b0); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_data", u_if.out_data, '0);
    check("arst_busy", FDS'(u_if.busy), '0);
    check("arst_pulses", FDS'({u_if.out_valid, u_if.frame_err}), '0);
    u_if.in_bit = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    exp_q.push_back(40'h0102030405);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    idle(2);
    check("t5_valid_count", FDS'(valid_seen - v0), FDS'(1));
    check("t5_out_data", u_if.out_data, 40'h0102030405);

`ifdef UART_FRAME_RX_PARITY_EN
    // wrong parity on AA aborts; a correctly-parity frame then decodes
    v0 = valid_seen; e0 = err_seen;
    send_byte(8'h10);
    send_byte_badpar(8'hAA);
    idle(2);
    check("par_err_count", FDS'(err_seen - e0), FDS'(1));
    check("par_no_valid", FDS'(valid_seen - v0), '0);
    send_frame(40'hAA55F00F3C, 40'hAA55F00F3C);
    idle(2);
    check("par_valid_count", FDS'(valid_seen - v0), FDS'(1));
`endif

    check("all_frames_seen", FDS'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
